operation_o_dispatch: RTL

- Upstream feeder and downstream collector for one operation_o-style execution unit with a ST/RD/RES handshake.
- Buffers operand pairs in a small FIFO and issues them one at a time to the unit.
- Pulses start, waits for ready, captures the result, and presents it on a valid/ack output port.
- Includes a watchdog so a hung unit cannot stall the pipeline.

---
 rtl/operation_o_dispatch.sv | 137 +++++++++++++
 1 files changed

// File: rtl/operation_o_dispatch.sv
// rtl/operation_o_dispatch.sv - operand FIFO feeder and result collector for an ST/RD/RES execution unit
// Ops issue one at a time; a watchdog turns a silent unit into an all-ones result plus a sticky ERR.
module operation_o_dispatch #(
    parameter int BW    = 16,
    parameter int DEPTH = 4,
    parameter int TMO   = 255
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          PUSH,
    input  logic [BW-1:0] PIN0,
    input  logic [BW-1:0] PIN1,
    output logic          FULL,
    output logic          EMPTY,
    output logic          OST,
    output logic [BW-1:0] OIN0,
    output logic [BW-1:0] OIN1,
    input  logic          ORD,
    input  logic [BW-1:0] ORES,
    output logic [BW-1:0] RES,
    output logic          RVALID,
    input  logic          RACK,
    output logic          ERR
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TMO + 1);
    localparam logic [AW:0]   L_FULL = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] L_TMO  = CW'(TMO);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [2*BW-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic [CW-1:0]   r_tmo_cnt;
    logic [BW-1:0]   r_oin0;
    logic [BW-1:0]   r_oin1;
    logic [BW-1:0]   r_res;
    logic            r_rvalid;
    logic            r_err;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_load;
    logic            w_timeout;

    assign w_full  = (r_count == L_FULL);
    assign w_empty = (r_count == '0);
    // A pop frees the head slot on the same edge, so a full FIFO may still take a push then.
    assign w_push  = PUSH && (!w_full || w_pop);

    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_load    = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_load = 1'b1;
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                if (ORD) begin
                    w_pop  = 1'b1;
                    w_next = S_HOLD;
                end else if (r_tmo_cnt == L_TMO) begin
                    w_pop     = 1'b1;
                    w_timeout = 1'b1;
                    w_next    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (RACK) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_tmo_cnt <= '0;
            r_oin0    <= '0;
            r_oin1    <= '0;
            r_res     <= '0;
            r_rvalid  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;

            if (w_load) begin
                r_oin0 <= r_mem[r_rptr][BW-1:0];
                r_oin1 <= r_mem[r_rptr][2*BW-1:BW];
            end

            if (r_state == S_ISSUE)                r_tmo_cnt <= '0;
            else if (r_state == S_WAIT && !w_pop) r_tmo_cnt <= r_tmo_cnt + 1'b1;

            if (r_state == S_WAIT && w_pop) begin
                r_rvalid <= 1'b1;
                r_res    <= w_timeout ? {BW{1'b1}} : ORES;
            end else if (r_state == S_HOLD && RACK) begin
                r_rvalid <= 1'b0;
            end

            if (w_timeout) r_err <= 1'b1;
        end
    end

    // Storage needs no reset: pointers and count define which slots are live.
    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wptr] <= {PIN1, PIN0};
    end

    assign FULL   = w_full;
    assign EMPTY  = w_empty;
    assign OST    = (r_state == S_ISSUE);
    assign OIN0   = r_oin0;
    assign OIN1   = r_oin1;
    assign RES    = r_res;
    assign RVALID = r_rvalid;
    assign ERR    = r_err;
endmodule
